// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: state encodings, opcodes and datapath select encodings for the multi-cycle controller
package riscv_mc_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECR    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_ALUWB    = 4'd10,
      S_BEQ      = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUREG  = 2'b00;
   localparam logic [1:0] RES_MEMDATA = 2'b01;
   localparam logic [1:0] RES_ALUOUT  = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // Dispatch target out of DECODE; anything unrecognised traps.
   function automatic state_t decode_target(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE: return S_MEMADR;
         OP_RTYPE:          return S_EXECR;
         OP_ITYPE:          return S_EXECI;
         OP_BRANCH:         return S_BEQ;
         OP_JAL:            return S_JAL;
         default:           return S_TRAP;
      endcase
   endfunction

endpackage

// File: rtl/riscv_mc_outdec.sv
// riscv_mc_outdec: combinational state-to-control decode for the multi-cycle controller
module riscv_mc_outdec
   import riscv_mc_pkg::*;
(
   input  state_t     state,
   input  logic       mem_ready,
   input  logic       zero,
   output logic       pc_write,
   output logic       ir_write,
   output logic       adr_src,
   output logic       mem_re,
   output logic       mem_we,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src
);

   logic pc_update;
   logic branch;

   // Moore decode per state; only the fetch handshake and branch outcome qualify PC/IR loads.
   always_comb begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALU_ADD;
      result_src = RES_ALUREG;
      case (state)
         S_FETCH: begin
            mem_re     = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALUOUT;
            ir_write   = mem_ready;
            pc_update  = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            mem_re  = 1'b1;
         end
         S_MEMWB: begin
            result_src = RES_MEMDATA;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src = 1'b1;
            mem_we  = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALU_FUNCT;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_FUNCT;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_update = 1'b1;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BEQ: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALU_SUB;
            branch    = 1'b1;
         end
         default: ;
      endcase
      pc_write = pc_update | (branch & zero);
   end

endmodule

// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multi-cycle RV32I main controller with shared memory port, stall handshake and sticky trap
module riscv_mc_control
   import riscv_mc_pkg::*;
#(
   parameter int RETIRE_CNT_W = 32
)(
   input  logic                    CLOCK_20,
   input  logic                    reset,
   input  logic [6:0]              opcode,
   input  logic                    zero,
   input  logic                    mem_ready,
   output logic                    pc_write,
   output logic                    ir_write,
   output logic                    adr_src,
   output logic                    mem_re,
   output logic                    mem_we,
   output logic                    reg_write,
   output logic [1:0]              alu_src_a,
   output logic [1:0]              alu_src_b,
   output logic [1:0]              alu_op,
   output logic [1:0]              result_src,
   output logic [3:0]              state,
   output logic                    illegal_instr,
   output logic [RETIRE_CNT_W-1:0] retire_cnt
);

   state_t cur;
   state_t nxt;
   logic   retire;

   // Next-state selection; memory states hold until the handshake completes.
   always_comb begin
      nxt = cur;
      case (cur)
         S_IDLE:                   nxt = S_FETCH;
         S_FETCH:                  nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:                 nxt = decode_target(opcode);
         S_MEMADR:                 nxt = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:                nxt = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE:               nxt = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECR, S_EXECI, S_JAL:  nxt = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BEQ:  nxt = S_FETCH;
         default:                  nxt = S_TRAP;
      endcase
   end

   assign retire = (cur == S_MEMWB) || (cur == S_ALUWB) || (cur == S_BEQ) ||
                   ((cur == S_MEMWRITE) && mem_ready);

   // State register, sticky trap flag and retired-instruction counter.
   always_ff @(posedge CLOCK_20 or posedge reset) begin
      if (reset) begin
         cur           <= S_IDLE;
         illegal_instr <= 1'b0;
         retire_cnt    <= '0;
      end else begin
         cur <= nxt;
         if (nxt == S_TRAP) illegal_instr <= 1'b1;
         if (retire) retire_cnt <= retire_cnt + RETIRE_CNT_W'(1);
      end
   end

   assign state = cur;

   riscv_mc_outdec u_outdec (
      .state      (cur),
      .mem_ready  (mem_ready),
      .zero       (zero),
      .pc_write   (pc_write),
      .ir_write   (ir_write),
      .adr_src    (adr_src),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .result_src (result_src)
   );

endmodule

// File: tb/tb_riscv_mc_control.sv
// tb_riscv_mc_control: directed scoreboard bench for the multi-cycle controller
module tb_riscv_mc_control;

   localparam int IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMREAD = 4, MEMWB = 5,
                  MEMWRITE = 6, EXECR = 7, EXECI = 8, JAL = 9, ALUWB = 10, BEQ = 11, TRAP = 12;

   localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                          BR = 7'b1100011, JL = 7'b1101111, BAD = 7'b1110011;

   logic        CLOCK_20 = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  opcode = 7'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_write, ir_write, adr_src, mem_re, mem_we, reg_write, illegal_instr;
   logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
   logic [3:0]  state;
   logic [31:0] retire_cnt;
   logic [18:0] obs;

   typedef struct {
      logic [18:0] c;
      logic [31:0] r;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          passed = 0;
   logic [31:0] exp_ret = 0;

   riscv_mc_control #(.RETIRE_CNT_W(32)) dut (
      .CLOCK_20      (CLOCK_20),
      .reset         (reset),
      .opcode        (opcode),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .ir_write      (ir_write),
      .adr_src       (adr_src),
      .mem_re        (mem_re),
      .mem_we        (mem_we),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .result_src    (result_src),
      .state         (state),
      .illegal_instr (illegal_instr),
      .retire_cnt    (retire_cnt)
   );

   always #5 CLOCK_20 = ~CLOCK_20;

   assign obs = {state, pc_write, ir_write, adr_src, mem_re, mem_we, reg_write, illegal_instr,
                 alu_src_a, alu_src_b, alu_op, result_src};

   function automatic logic [18:0] ctl(input int st, input logic mr, input logic z);
      logic       pcw, irw, adr, re, we, rw, ill;
      logic [1:0] a, b, op, res;
      logic [3:0] s;
      {pcw, irw, adr, re, we, rw, ill} = '0;
      {a, b, op, res} = '0;
      s = st[3:0];
      case (st)
         FETCH:    begin re = 1; b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
         DECODE:   begin a = 2'b01; b = 2'b01; end
         MEMADR:   begin a = 2'b10; b = 2'b01; end
         MEMREAD:  begin adr = 1; re = 1; end
         MEMWB:    begin res = 2'b01; rw = 1; end
         MEMWRITE: begin adr = 1; we = 1; end
         EXECR:    begin a = 2'b10; op = 2'b10; end
         EXECI:    begin a = 2'b10; b = 2'b01; op = 2'b10; end
         JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
         ALUWB:    rw = 1;
         BEQ:      begin a = 2'b10; op = 2'b01; pcw = z; end
         TRAP:     ill = 1;
         default:  ;
      endcase
      return {s, pcw, irw, adr, re, we, rw, ill, a, b, op, res};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, got, want);
   endtask

   task automatic step(input int st, input logic rs, input logic mr, input logic z, input logic [6:0] op);
      exp_t e;
      @(negedge CLOCK_20);
      reset = rs;
      mem_ready = mr;
      zero = z;
      opcode = op;
      if (rs) exp_ret = 0;
      sb.push_back('{c: ctl(st, mr, z), r: exp_ret});
      if (!rs && (st == MEMWB || st == ALUWB || st == BEQ || (st == MEMWRITE && mr))) exp_ret++;
      #2;
      e = sb.pop_front();
      chk($sformatf("ctl_state%0d", st), 32'(obs), 32'(e.c));
      chk($sformatf("retire_state%0d", st), retire_cnt, e.r);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step(IDLE, 1, 0, 0, RT);
      step(IDLE, 1, 0, 0, RT);
      step(IDLE, 0, 1, 0, RT);
      // R-type, zero-wait
      step(FETCH, 0, 1, 0, RT);
      step(DECODE, 0, 1, 0, RT);
      step(EXECR, 0, 1, 0, RT);
      step(ALUWB, 0, 1, 0, RT);
      // async reset in the middle of a stalled fetch
      step(FETCH, 0, 0, 0, RT);
      #1 reset = 1'b1;
      #1;
      chk("async_mem_re", {31'd0, mem_re}, 32'd0);
      chk("async_state", {28'd0, state}, IDLE);
      exp_ret = 0;
      step(IDLE, 1, 1, 0, RT);
      step(IDLE, 1, 1, 0, RT);
      step(IDLE, 1, 1, 0, RT);
      step(IDLE, 0, 0, 0, LD);
      // load with 3 wait cycles on fetch and read
      for (int i = 0; i < 3; i++) step(FETCH, 0, 0, 0, LD);
      step(FETCH, 0, 1, 0, LD);
      step(DECODE, 0, 1, 0, LD);
      step(MEMADR, 0, 1, 1, LD);
      for (int i = 0; i < 3; i++) step(MEMREAD, 0, 0, 0, LD);
      step(MEMREAD, 0, 1, 0, LD);
      step(MEMWB, 0, 1, 0, LD);
      // branch taken then not taken
      step(FETCH, 0, 1, 1, BR);
      step(DECODE, 0, 1, 1, BR);
      step(BEQ, 0, 1, 1, BR);
      step(FETCH, 0, 1, 0, BR);
      step(DECODE, 0, 1, 0, BR);
      step(BEQ, 0, 1, 0, BR);
      // store with one wait, then JAL
      step(FETCH, 0, 1, 0, ST);
      step(DECODE, 0, 1, 0, ST);
      step(MEMADR, 0, 0, 0, ST);
      step(MEMWRITE, 0, 0, 0, ST);
      step(MEMWRITE, 0, 1, 0, ST);
      step(FETCH, 0, 1, 0, JL);
      step(DECODE, 0, 1, 0, JL);
      step(JAL, 0, 1, 0, JL);
      step(ALUWB, 0, 1, 0, JL);
      // illegal opcode traps and stays
      step(FETCH, 0, 1, 0, BAD);
      step(DECODE, 0, 1, 1, BAD);
      for (int i = 0; i < 20; i++) step(TRAP, 0, i[0], 1, (i[1] ? RT : BAD));
      step(IDLE, 1, 0, 0, RT);
      step(IDLE, 0, 1, 0, RT);
      step(FETCH, 0, 1, 0, RT);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
